// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
//   state_t  : controller states
//   MODE_SUB : subtractive Euclid algorithm select
//   MODE_BIN : binary (Stein) algorithm select
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SUB,
    BIN,
    DONE
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration step.
//   a, b     : current operands
//   k        : current common power-of-two count (binary mode)
//   mode     : MODE_SUB or MODE_BIN
//   a_next, b_next, k_next : operand/shift values for the next cycle
//   eq       : operands are equal; iteration terminates this cycle
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHIFT_W-1:0] k,
  input  logic               mode,
  output logic [WIDTH-1:0]   a_next,
  output logic [WIDTH-1:0]   b_next,
  output logic [SHIFT_W-1:0] k_next,
  output logic               eq
);

  always_comb begin
    a_next = a;
    b_next = b;
    k_next = k;
    eq     = (a == b);
    if (!eq) begin
      if (mode == MODE_SUB) begin
        if (a > b) a_next = a - b;
        else       b_next = b - a;
      end else begin
        // Priority order: common factor of two, then single evens,
        // then odd-odd subtract (difference is even, so halve it too).
        if (!a[0] && !b[0]) begin
          a_next = a >> 1;
          b_next = b >> 1;
          k_next = k + SHIFT_W'(1);
        end else if (!a[0]) begin
          a_next = a >> 1;
        end else if (!b[0]) begin
          b_next = b >> 1;
        end else if (a > b) begin
          a_next = (a - b) >> 1;
        end else begin
          b_next = (b - a) >> 1;
        end
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD coprocessor (subtractive Euclid or binary Stein).
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (accepted only in IDLE)
//   a_in, b_in, mode    : operands and algorithm select, sampled on accept
//   out_valid/out_ready : result handshake (held in DONE)
//   gcd_out             : GCD result
//   iter_out            : iteration cycles used, saturating
//   zero_err            : both operands were zero
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ITER_W  = 17,
  parameter int SHIFT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  gcd_out,
  output logic [ITER_W-1:0] iter_out,
  output logic              zero_err
);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, b_q, res_q;
  logic [SHIFT_W-1:0]  k_q;
  logic [ITER_W-1:0]   cnt_q;
  logic                mode_q, zero_q;

  logic [WIDTH-1:0]    a_nx, b_nx;
  logic [SHIFT_W-1:0]  k_nx;
  logic                eq;

  gcd_step #(
    .WIDTH  (WIDTH),
    .SHIFT_W(SHIFT_W)
  ) u_step (
    .a     (a_q),
    .b     (b_q),
    .k     (k_q),
    .mode  (mode_q),
    .a_next(a_nx),
    .b_next(b_nx),
    .k_next(k_nx),
    .eq    (eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE:    if (in_valid) state_d = CHECK;
      CHECK:   if (a_q == '0 || b_q == '0) state_d = DONE;
               else if (mode_q == MODE_BIN) state_d = BIN;
               else state_d = SUB;
      SUB,
      BIN:     if (eq) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      mode_q <= MODE_SUB;
      zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q    <= a_in;
          b_q    <= b_in;
          mode_q <= mode;
          k_q    <= '0;
          cnt_q  <= '0;
          res_q  <= '0;
          zero_q <= 1'b0;
        end
        CHECK: begin
          if (a_q == '0 && b_q == '0) zero_q <= 1'b1;
          else if (a_q == '0)         res_q  <= b_q;
          else if (b_q == '0)         res_q  <= a_q;
        end
        SUB, BIN: begin
          if (cnt_q != '1) cnt_q <= cnt_q + ITER_W'(1);
          if (eq) begin
            res_q <= (mode_q == MODE_BIN) ? (a_q << k_q) : a_q;
          end else begin
            a_q <= a_nx;
            b_q <= b_nx;
            k_q <= k_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign gcd_out  = res_q;
  assign iter_out = cnt_q;
  assign zero_err = zero_q;

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised iterative greatest-common-divisor unit with separate datapath and controller, built as a single block.
- Takes two WIDTH-bit unsigned operands over a valid/ready input handshake and computes GCD in one of two run-time-selectable algorithms: subtractive Euclid or binary (Stein).
- Returns the result plus an iteration count over a valid/ready output handshake.
- Sits as a coprocessor slave behind a simple request/response stream.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).
- ITER_W, 17, width of the iteration counter (saturating).
- SHIFT_W, 5, width of the binary-mode common-power-of-two counter k (must hold WIDTH).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  engine can accept operands (IDLE only).
- a_in  in  WIDTH  operand A, unsigned.
- b_in  in  WIDTH  operand B, unsigned.
- mode  in  1  0 = subtractive Euclid, 1 = binary Stein; sampled with operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- gcd_out  out  WIDTH  GCD result, held stable while out_valid=1.
- iter_out  out  ITER_W  number of iteration cycles used, saturating at all-ones.
- zero_err  out  1  both operands were zero; gcd_out=0; qualified by out_valid.

Behaviour:
- Reset (async assert, synchronous-release use):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, gcd_out=0, iter_out=0, zero_err=0.
  - Internal A, B, k and counter are cleared.
- Reset mid-operation aborts the computation; no result is produced.
- States: IDLE, CHECK, SUB, BIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch A<=a_in, B<=b_in, mode, clear k and counter, then go to CHECK.
- CHECK (1 cycle, not counted):
  - A==0 and B==0: result 0, zero_err=1, go to DONE.
  - Exactly one operand is zero: result = the other operand, go to DONE.
  - Otherwise go to SUB (mode 0) or BIN (mode 1).
- SUB (each cycle counter+1):
  - A==B: result=A, go to DONE.
  - A>B: A<=A-B.
  - Otherwise B<=B-A.
- BIN (each cycle counter+1, priority order):
  - A==B: result = A<<k, truncated to WIDTH (cannot overflow since the true GCD fits), go to DONE.
  - A and B both even: A>>=1, B>>=1, k+1.
  - A even: A>>=1.
  - B even: B>>=1.
  - A>B: A<=(A-B)>>1.
  - Otherwise B<=(B-A)>>1.
- Terminating cycle: counted; out_valid rises on the next edge.
- DONE:
  - out_valid=1; gcd_out, iter_out and zero_err are held constant.
  - On out_valid&out_ready, go to IDLE: out_valid=0 and in_ready=1 next cycle. There is no same-cycle turnaround.
- Latency: accept edge, then 1 CHECK cycle, then N iteration cycles, then out_valid.
- Backpressure: DONE holds indefinitely while out_ready=0. in_valid is ignored outside IDLE.
- Arithmetic: all unsigned. Subtraction only ever runs with larger minus smaller, so there is no wrap. The counter saturates at 2^ITER_W-1 and does not wrap.
- mode or operand changes after acceptance have no effect.

Decomposition:
- gcd_pkg holds:
  - state enum (IDLE, CHECK, SUB, BIN, DONE).
  - mode constants MODE_SUB=0, MODE_BIN=1.
- One combinational sub-module, gcd_step:
  - Inputs: A, B, k, mode.
  - Outputs: next A, B, k, and an eq flag.
  - Instantiated once.
- Controller FSM and output registers stay in gcd_engine.

Test Plan:
- mode=0, A=48, B=18 -> out_valid, gcd_out=6, iter_out=5, zero_err=0.
- mode=1, A=48, B=18 -> gcd_out=6, iter_out=6.
- A=0, B=25 (either mode) -> gcd_out=25, iter_out=0, zero_err=0. A=0, B=0 -> gcd_out=0, zero_err=1.
- mode=0, A=65535, B=1, WIDTH=16 -> gcd_out=1, iter_out=65535. Repeat with ITER_W=8 -> iter_out=255 (saturated).
- Backpressure: A=12, B=8, out_ready=0 for 10 cycles -> out_valid high and outputs stable throughout, in_ready=0. Second in_valid during this window is ignored. out_ready=1 -> IDLE, then the next request is accepted.
- Assert rst_n=0 mid-SUB (A=1000, B=3) -> immediate IDLE, all outputs 0. A new request after release yields the correct result with no residue.
